// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: column drive, row synchroniser, frame-level debounce and a
// one-strobe-per-press FSM producing a hex key code.
module keypad_scanner #(
    parameter int unsigned SCAN_DIV     = 125_000,
    parameter int unsigned STABLE_SCANS = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] keypad_value,
    output logic       keypress,
    output logic       key_held
);

    localparam int unsigned CntW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned StbW = $clog2(STABLE_SCANS + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(SCAN_DIV - 1);
    localparam logic [StbW-1:0] StbMax = StbW'(STABLE_SCANS);

    typedef enum logic [1:0] {ClsNone, ClsOne, ClsMulti} cls_e;
    typedef enum logic {StIdle, StPressed} state_e;

    logic [3:0]      row_meta_q, row_sync_q;
    logic [CntW-1:0] cnt_q;
    logic [1:0]      col_idx_q;
    logic [3:0]      col_q;
    cls_e            acc_cls_q, prev_cls_q, cls_m;
    logic [3:0]      acc_code_q, prev_code_q, code_m;
    logic [StbW-1:0] stable_q, stable_d;
    state_e          state_q, state_d;
    logic [3:0]      value_q, value_d;
    logic            keypress_q, keypress_d;

    logic       dwell_end, frame_end, same;
    logic [3:0] row_low;
    logic       any_low, one_low;
    logic [1:0] hit_row;
    logic [3:0] cur_code;

    function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] code;
        case ({r, c})
            4'h0: code = 4'h1;  4'h1: code = 4'h2;  4'h2: code = 4'h3;  4'h3: code = 4'hA;
            4'h4: code = 4'h4;  4'h5: code = 4'h5;  4'h6: code = 4'h6;  4'h7: code = 4'hB;
            4'h8: code = 4'h7;  4'h9: code = 4'h8;  4'hA: code = 4'h9;  4'hB: code = 4'hC;
            4'hC: code = 4'h0;  4'hD: code = 4'hF;  4'hE: code = 4'hE;  default: code = 4'hD;
        endcase
        return code;
    endfunction

    assign dwell_end = (cnt_q == CntMax);
    assign frame_end = dwell_end && (col_idx_q == 2'd3);
    assign row_low   = ~row_sync_q;
    assign any_low   = |row_low;
    assign one_low   = any_low && ((row_low & (row_low - 4'd1)) == 4'd0);

    always_comb begin
        hit_row = 2'd0;
        case (row_low)
            4'b0010: hit_row = 2'd1;
            4'b0100: hit_row = 2'd2;
            4'b1000: hit_row = 2'd3;
            default: hit_row = 2'd0;
        endcase
    end

    assign cur_code = key_code(hit_row, col_idx_q);

    // Fold the current column's sample into the frame accumulated so far.
    always_comb begin
        cls_m  = acc_cls_q;
        code_m = acc_code_q;
        if (any_low) begin
            if (acc_cls_q == ClsNone && one_low) begin
                cls_m  = ClsOne;
                code_m = cur_code;
            end else begin
                cls_m = ClsMulti;
            end
        end
    end

    always_comb begin
        same     = (cls_m == prev_cls_q) && ((cls_m != ClsOne) || (code_m == prev_code_q));
        stable_d = StbW'(1);
        if (same) begin
            stable_d = (stable_q == StbMax) ? StbMax : stable_q + StbW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            row_meta_q  <= 4'hF;
            row_sync_q  <= 4'hF;
            cnt_q       <= '0;
            col_idx_q   <= 2'd0;
            col_q       <= 4'b1110;
            acc_cls_q   <= ClsNone;
            acc_code_q  <= 4'h0;
            prev_cls_q  <= ClsNone;
            prev_code_q <= 4'h0;
            stable_q    <= '0;
            value_q     <= 4'h0;
            keypress_q  <= 1'b0;
        end else begin
            row_meta_q <= row;
            row_sync_q <= row_meta_q;
            value_q    <= value_d;
            keypress_q <= keypress_d;
            if (dwell_end) begin
                cnt_q     <= '0;
                col_idx_q <= col_idx_q + 2'd1;
                col_q     <= {col_q[2:0], col_q[3]};
                if (frame_end) begin
                    acc_cls_q   <= ClsNone;
                    acc_code_q  <= 4'h0;
                    prev_cls_q  <= cls_m;
                    prev_code_q <= code_m;
                    stable_q    <= stable_d;
                end else begin
                    acc_cls_q  <= cls_m;
                    acc_code_q <= code_m;
                end
            end else begin
                cnt_q <= cnt_q + CntW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // A different key or a multi-press while PRESSED is ignored until a confirmed release.
    always_comb begin
        state_d = state_q;
        if (frame_end && stable_d == StbMax) begin
            unique case (state_q)
                StIdle:    if (cls_m == ClsOne)  state_d = StPressed;
                StPressed: if (cls_m == ClsNone) state_d = StIdle;
                default:   state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        keypress_d = (state_q == StIdle) && (state_d == StPressed);
        value_d    = keypress_d ? code_m : value_q;
    end

    assign col          = col_q;
    assign keypad_value = value_q;
    assign keypress     = keypress_q;
    assign key_held     = (state_q == StPressed);

endmodule
